// File: rtl/pipe_add_pkg.sv
// Shared helpers for the chunked pipelined adder: chunk extraction and
// parameter legality check used at elaboration.
package pipe_add_pkg;

  localparam int MAX_WIDTH  = 512;
  localparam int MAX_STAGES = 8;

  // Returns vec[k*chunk +: chunk], zero-extended to MAX_WIDTH bits.
  function automatic logic [MAX_WIDTH-1:0] chunk_of(input logic [MAX_WIDTH-1:0] vec,
                                                    input int k,
                                                    input int chunk);
    logic [MAX_WIDTH-1:0] mask;
    mask = {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - chunk);
    return (vec >> (k * chunk)) & mask;
  endfunction

  function automatic bit cfg_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= MAX_STAGES) && (width >= stages) &&
           (width <= MAX_WIDTH) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipe_add_slice.sv
// One pipeline stage: CHUNK-bit add of operand chunks plus incoming carry,
// registered together with the beat's valid bit when the pipe advances.
module pipe_add_slice #(
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             c_in,
  output logic             valid_q,
  output logic [CHUNK-1:0] res_q,
  output logic             carry_q
);

  logic [CHUNK:0] sum_d;

  always_comb begin
    sum_d = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, c_in};
  end

  // NOTE: non-blocking (<=) for all flop state so every stage samples the
  // previous stage's pre-edge value; blocking here would collapse the pipe.
  // NOTE: data flops are reset too, so sum/c_out/ovf read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      res_q   <= '0;
      carry_q <= 1'b0;
    end else if (en) begin
      valid_q          <= in_valid;
      {carry_q, res_q} <= sum_d;
    end
  end

endmodule

// File: rtl/pipe_adder_n.sv
// Parametrised STAGES-deep pipelined adder/subtractor with valid/ready
// handshake; the top owns operand skew, result deskew and flow control.
module pipe_adder_n
  import pipe_add_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipe_adder_n: WIDTH must be a multiple of STAGES, STAGES in 1..8");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // a_q/b_q[s]: operands travelling alongside stage s; lo_q[s]: result chunks
  // 0..s-1 already resolved; full[s]: lo_q[s] merged with stage s's chunk.
  logic [WIDTH-1:0] a_d  [STAGES];
  logic [WIDTH-1:0] a_q  [STAGES];
  logic [WIDTH-1:0] b_d  [STAGES];
  logic [WIDTH-1:0] b_q  [STAGES];
  logic [WIDTH-1:0] lo_d [STAGES];
  logic [WIDTH-1:0] lo_q [STAGES];
  logic [WIDTH-1:0] full [STAGES];

  logic [CHUNK-1:0] sl_a   [STAGES];
  logic [CHUNK-1:0] sl_b   [STAGES];
  logic [CHUNK-1:0] sl_res [STAGES];
  logic             sl_cin [STAGES];
  logic             sl_vin [STAGES];
  logic             sl_v   [STAGES];
  logic             sl_cy  [STAGES];

  // NOTE: every variable gets a value on every pass through this block, so
  // no latches are inferred.
  always_comb begin
    b_eff   = sub ? ~b : b;
    cin_eff = sub ^ c_in;

    for (int s = 0; s < STAGES; s++) begin
      full[s] = lo_q[s] | (WIDTH'(sl_res[s]) << (s * CHUNK));
    end

    a_d[0]    = a;
    b_d[0]    = b_eff;
    lo_d[0]   = '0;
    sl_a[0]   = CHUNK'(chunk_of(MAX_WIDTH'(a), 0, CHUNK));
    sl_b[0]   = CHUNK'(chunk_of(MAX_WIDTH'(b_eff), 0, CHUNK));
    sl_cin[0] = cin_eff;
    sl_vin[0] = in_valid;

    for (int s = 1; s < STAGES; s++) begin
      a_d[s]    = a_q[s-1];
      b_d[s]    = b_q[s-1];
      lo_d[s]   = full[s-1];
      sl_a[s]   = CHUNK'(chunk_of(MAX_WIDTH'(a_q[s-1]), s, CHUNK));
      sl_b[s]   = CHUNK'(chunk_of(MAX_WIDTH'(b_q[s-1]), s, CHUNK));
      sl_cin[s] = sl_cy[s-1];
      sl_vin[s] = sl_v[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        a_q[s]  <= '0;
        b_q[s]  <= '0;
        lo_q[s] <= '0;
      end
    end else if (adv) begin
      for (int s = 0; s < STAGES; s++) begin
        a_q[s]  <= a_d[s];
        b_q[s]  <= b_d[s];
        lo_q[s] <= lo_d[s];
      end
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_slice
    pipe_add_slice #(.CHUNK(CHUNK)) u_slice (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (adv),
      .in_valid (sl_vin[s]),
      .a        (sl_a[s]),
      .b        (sl_b[s]),
      .c_in     (sl_cin[s]),
      .valid_q  (sl_v[s]),
      .res_q    (sl_res[s]),
      .carry_q  (sl_cy[s])
    );
  end

  // Whole pipe moves as one: a stalled output freezes every stage.
  assign adv       = !sl_v[LAST] || out_ready;
  assign in_ready  = adv;
  assign out_valid = sl_v[LAST];
  assign sum       = full[LAST];
  assign c_out     = sl_cy[LAST];
  assign ovf       = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &&
                     (full[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);

endmodule
